// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port between the writeback stage (priority) and a
// small queue of secondary writes, with WAW kill, pending lookup and starvation relief.
module reg_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W       = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [4:0]       wb_id,
  input  logic [31:0]      wb_value,
  input  logic             sec_valid,
  input  logic [4:0]       sec_id,
  input  logic [31:0]      sec_value,
  output logic             sec_ready,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  output logic             pend_rs,
  output logic             pend_rt,
  output logic             control_reg_write,
  output logic [4:0]       control_write_id,
  output logic [31:0]      reg_write_value,
  output logic             starve_stall,
  output logic [OCC_W-1:0] occupancy,
  output logic             protocol_err
);

  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [3:0]       STARVE_C = 4'(STARVE_LIMIT);

  logic [4:0]       q_id    [DEPTH];
  logic [31:0]      q_value [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] slot_cnt;
  logic [3:0]       wait_cnt;
  logic             err_q;

  logic             head_live;
  logic             head_dead;
  logic             grant_head;
  logic             grant_wb;
  logic             push;
  logic             pop;
  logic             kill_en;
  logic [OCC_W-1:0] live_cnt;

  function automatic logic [OCC_W-1:0] count_live(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  // Valid bits are cleared on pop, so a set bit at head implies an occupied slot.
  assign head_live    = q_valid[head];
  assign head_dead    = (slot_cnt != '0) && !q_valid[head];
  assign live_cnt     = count_live(q_valid);
  assign starve_stall = !reset && (wait_cnt == STARVE_C);
  assign grant_head   = !reset && head_live && (starve_stall || !wb_valid);
  assign grant_wb     = !reset && !starve_stall && wb_valid;
  assign kill_en      = grant_wb && (wb_id != 5'd0);
  // Killed entries still hold physical slots, so readiness follows slot usage.
  assign sec_ready    = !reset && (slot_cnt < DEPTH_C);
  assign push         = sec_valid && sec_ready && (sec_id != 5'd0);
  assign pop          = grant_head || head_dead;
  assign occupancy    = reset ? '0 : live_cnt;
  assign protocol_err = err_q;

  assign control_reg_write = grant_head || grant_wb;
  assign control_write_id  = grant_head ? q_id[head]    : wb_id;
  assign reg_write_value   = grant_head ? q_value[head] : wb_value;

  always_comb begin
    pend_rs = 1'b0;
    pend_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (q_id[i] == rs_id)) pend_rs = 1'b1;
      if (q_valid[i] && (q_id[i] == rt_id)) pend_rt = 1'b1;
    end
    if (reset || (rs_id == 5'd0)) pend_rs = 1'b0;
    if (reset || (rt_id == 5'd0)) pend_rt = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      slot_cnt <= '0;
      q_valid  <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // The writeback is newer than anything queued for the same register.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (q_id[i] == wb_id)) q_valid[i] <= 1'b0;
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      slot_cnt <= slot_cnt + OCC_W'(push) - OCC_W'(pop);

      if (grant_head || (live_cnt == '0)) begin
        wait_cnt <= '0;
      end else if (head_live && (wait_cnt != STARVE_C)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (wb_valid && starve_stall) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_id[tail]    <= sec_id;
      q_value[tail] <= sec_value;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-of-entries reference model.
module tb_reg_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wb_valid;
  logic [4:0]             wb_id;
  logic [31:0]            wb_value;
  logic                   sec_valid;
  logic [4:0]             sec_id;
  logic [31:0]            sec_value;
  logic                   sec_ready;
  logic [4:0]             rs_id;
  logic [4:0]             rt_id;
  logic                   pend_rs;
  logic                   pend_rt;
  logic                   control_reg_write;
  logic [4:0]             control_write_id;
  logic [31:0]            reg_write_value;
  logic                   starve_stall;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   protocol_err;

  reg_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_value(wb_value),
    .sec_valid(sec_valid), .sec_id(sec_id), .sec_value(sec_value), .sec_ready(sec_ready),
    .rs_id(rs_id), .rt_id(rt_id), .pend_rs(pend_rs), .pend_rt(pend_rt),
    .control_reg_write(control_reg_write), .control_write_id(control_write_id),
    .reg_write_value(reg_write_value), .starve_stall(starve_stall),
    .occupancy(occupancy), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  id;
    logic [31:0] val;
    bit          live;
  } ent_t;

  typedef struct {
    bit          ready;
    bit          stall;
    bit          wr;
    bit          gh;
    bit          gw;
    bit          prs;
    bit          prt;
    logic [4:0]  wid;
    logic [31:0] wval;
    int          occ;
  } exp_t;

  ent_t mq[$];
  int   mwait = 0;
  bit   merr = 0;
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;
  bit   saw_aaaa = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    bit   live_head;
    e = '{default: 0};
    if (reset) return e;
    live_head = (mq.size() > 0) && mq[0].live;
    foreach (mq[i]) begin
      if (mq[i].live) begin
        e.occ++;
        if (rs_id != 0 && mq[i].id == rs_id) e.prs = 1;
        if (rt_id != 0 && mq[i].id == rt_id) e.prt = 1;
      end
    end
    e.ready = mq.size() < DEPTH;
    e.stall = (mwait == LIMIT);
    if (e.stall)        e.gh = live_head;
    else if (wb_valid)  e.gw = 1;
    else                e.gh = live_head;
    e.wr = e.gh || e.gw;
    if (e.gh) begin
      e.wid  = mq[0].id;
      e.wval = mq[0].val;
    end else if (e.gw) begin
      e.wid  = wb_id;
      e.wval = wb_value;
    end
    return e;
  endfunction

  // Every-cycle comparison against the reference model.
  always @(negedge clock) begin
    exp_t e;
    if (started) begin
      e = expect_now();
      chk("sec_ready", sec_ready, e.ready);
      chk("starve_stall", starve_stall, e.stall);
      chk("reg_write", control_reg_write, e.wr);
      chk("occupancy", occupancy, e.occ);
      chk("pend_rs", pend_rs, e.prs);
      chk("pend_rt", pend_rt, e.prt);
      chk("protocol_err", protocol_err, merr);
      if (e.wr) begin
        chk("write_id", control_write_id, e.wid);
        chk("write_value", reg_write_value, e.wval);
      end
      if (control_reg_write === 1'b1 && reg_write_value === 32'hAAAA) saw_aaaa = 1;
    end
  end

  // Reference model state update.
  always @(posedge clock) begin
    exp_t e;
    bit   do_pop;
    e = expect_now();
    if (reset) begin
      mq.delete();
      mwait = 0;
      merr  = 0;
    end else begin
      do_pop = e.gh || (mq.size() > 0 && !mq[0].live);
      if (e.gh || e.occ == 0) mwait = 0;
      else if (mq[0].live && mwait < LIMIT) mwait++;
      if (wb_valid && e.stall) merr = 1;
      if (e.gw && wb_id != 0) begin
        foreach (mq[i]) if (mq[i].id == wb_id) mq[i].live = 0;
      end
      if (do_pop) void'(mq.pop_front());
      if (sec_valid && e.ready && sec_id != 0) mq.push_back('{sec_id, sec_value, 1'b1});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic idle();
    wb_valid = 0; wb_id = 0; wb_value = 0;
    sec_valid = 0; sec_id = 0; sec_value = 0;
  endtask

  initial begin
    int pct;
    idle();
    rs_id = 0; rt_id = 0; reset = 1;
    cyc();
    started = 1;
    neg();
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", sec_ready, 0);
    chk("rst_wr", control_reg_write, 0);
    chk("rst_stall", starve_stall, 0);
    cyc();

    // Single secondary write drains into an idle port.
    reset = 0; sec_valid = 1; sec_id = 8; sec_value = 32'h11; rs_id = 8;
    neg(); chk("t1_ready", sec_ready, 1); chk("t1_wr0", control_reg_write, 0); cyc();
    idle();
    neg();
    chk("t1_wr", control_reg_write, 1); chk("t1_id", control_write_id, 8);
    chk("t1_val", reg_write_value, 32'h11); chk("t1_pend", pend_rs, 1); chk("t1_occ1", occupancy, 1);
    cyc();
    neg(); chk("t1_occ0", occupancy, 0); chk("t1_pend0", pend_rs, 0); cyc();

    // Fill queue under continuous writeback until starvation forces a slot.
    wb_valid = 1; wb_id = 3; wb_value = 32'h300;
    sec_valid = 1; sec_id = 9; sec_value = 32'h99; rt_id = 9;
    neg(); cyc();
    sec_id = 10; sec_value = 32'h1010;
    neg(); chk("t2_wb_b", control_write_id, 3); cyc();
    sec_valid = 0;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t2_ready", sec_ready, 0); chk("t2_occ", occupancy, 2);
      chk("t2_wbid", control_write_id, 3); chk("t2_nostall", starve_stall, 0);
      cyc();
    end
    wb_valid = 0;
    neg();
    chk("t2_stall", starve_stall, 1); chk("t2_wr", control_reg_write, 1);
    chk("t2_id9", control_write_id, 9); chk("t2_val9", reg_write_value, 32'h99);
    cyc();
    wb_valid = 1;
    neg(); chk("t2_stall_off", starve_stall, 0); chk("t2_wb_again", control_write_id, 3); chk("t2_occ1", occupancy, 1); cyc();
    wb_valid = 0;
    neg(); chk("t2_id10", control_write_id, 10); cyc();
    neg(); chk("t2_empty", occupancy, 0); cyc();

    // WAW kill: queued id 5 must never reach the port.
    saw_aaaa = 0;
    wb_valid = 1; wb_id = 3; wb_value = 32'h1;
    sec_valid = 1; sec_id = 5; sec_value = 32'hAAAA; rs_id = 5;
    neg(); cyc();
    sec_valid = 0; wb_id = 5; wb_value = 32'hBBBB;
    neg(); chk("t3_pend", pend_rs, 1); chk("t3_val", reg_write_value, 32'hBBBB); cyc();
    idle();
    neg(); chk("t3_pend0", pend_rs, 0); chk("t3_occ", occupancy, 0); chk("t3_nowr", control_reg_write, 0); cyc();
    neg(); cyc();
    chk("t3_no_aaaa", saw_aaaa, 0);

    // Secondary write to $0 is swallowed.
    sec_valid = 1; sec_id = 0; sec_value = 32'h77;
    neg(); chk("t4_ready", sec_ready, 1); cyc();
    idle();
    neg(); chk("t4_occ", occupancy, 0); chk("t4_nowr", control_reg_write, 0); cyc();

    // Writeback asserted during a stall raises the sticky error.
    wb_valid = 1; wb_id = 3; wb_value = 32'h333;
    sec_valid = 1; sec_id = 12; sec_value = 32'hC12;
    neg(); cyc();
    sec_valid = 0;
    repeat (4) begin neg(); cyc(); end
    neg();
    chk("t5_stall", starve_stall, 1); chk("t5_id", control_write_id, 12);
    chk("t5_val", reg_write_value, 32'hC12); chk("t5_err0", protocol_err, 0);
    cyc();
    idle();
    repeat (3) begin neg(); chk("t5_err", protocol_err, 1); cyc(); end

    // Reset with two entries queued drops them.
    wb_valid = 1; wb_id = 3; sec_valid = 1; sec_id = 20; sec_value = 32'h1; rs_id = 20; rt_id = 21;
    neg(); cyc();
    sec_id = 21;
    neg(); cyc();
    sec_valid = 0;
    neg(); chk("t6_occ2", occupancy, 2); chk("t6_pend", pend_rt, 1); cyc();
    wb_valid = 0; reset = 1;
    neg(); chk("t6_rst_occ", occupancy, 0); chk("t6_rst_wr", control_reg_write, 0); chk("t6_rst_pend", pend_rs, 0); cyc();
    reset = 0;
    neg();
    chk("t6_occ", occupancy, 0); chk("t6_wr", control_reg_write, 0);
    chk("t6_prs", pend_rs, 0); chk("t6_prt", pend_rt, 0); chk("t6_err", protocol_err, 0);
    cyc();

    // Random traffic with small id range to force collisions and kills.
    for (int n = 0; n < 4000; n++) begin
      pct       = ((n / 500) % 2 == 1) ? 85 : 40;
      reset     = ($urandom_range(0, 299) == 0);
      wb_valid  = ($urandom_range(0, 99) < pct);
      wb_id     = 5'($urandom_range(0, 7));
      wb_value  = $urandom;
      sec_valid = ($urandom_range(0, 1) == 1);
      sec_id    = 5'($urandom_range(0, 7));
      sec_value = $urandom;
      rs_id     = 5'($urandom_range(0, 7));
      rt_id     = 5'($urandom_range(0, 7));
      neg();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
